// File: rtl/irrigacao_sched.sv
// irrigacao_sched: multi-channel irrigation scheduler.
// Button front end selects a channel and edits its watering period (days),
// a free-running day prescaler counts every channel down independently, and
// a round-robin arbiter runs at most one pump at a time for PUMP_TICKS cycles.
// Optional feature: define MANUAL_RUN_EN to let bt_del in SELECT request an
// immediate watering of the selected channel.
module irrigacao_sched #(
    parameter int N_CH          = 3,
    parameter int PERIOD_W      = 4,
    parameter int TICKS_PER_DAY = 5184000,
    parameter int PUMP_TICKS    = 600,
    localparam int CH_W         = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bt_up,
    input  logic                bt_down,
    input  logic                bt_ok,
    input  logic                bt_del,
    output logic [N_CH-1:0]     pump,
    output logic [CH_W-1:0]     disp_ch,
    output logic [PERIOD_W-1:0] disp_val,
    output logic                disp_edit
);

    localparam int PRE_W = (TICKS_PER_DAY > 1) ? $clog2(TICKS_PER_DAY) : 1;
    localparam int CNT_W = (PUMP_TICKS > 1) ? $clog2(PUMP_TICKS) : 1;
    localparam int unsigned N_CH_U = N_CH;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_DAY - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PUMP_TICKS - 1);
    localparam logic [CH_W-1:0]  SEL_LAST = CH_W'(N_CH - 1);

    typedef enum logic {S_SELECT, S_EDIT} state_t;

    state_t              state;
    logic [CH_W-1:0]     sel;
    logic [PERIOD_W-1:0] edit_val;
    logic [PERIOD_W-1:0] period    [N_CH];
    logic [PERIOD_W-1:0] days_left [N_CH];
    logic [N_CH-1:0]     pending;
    logic [CNT_W-1:0]    pump_cnt;
    logic [CH_W-1:0]     last;
    logic [PRE_W-1:0]    presc;
    logic                day_tick;

    logic prev_up, prev_down, prev_ok, prev_del;
    logic e_up, e_down, e_ok, e_del;
    logic act_up, act_down, act_ok, act_del;

    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;
    int unsigned     idx;

    // Free-running day prescaler; day_tick marks the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign day_tick = (presc == PRE_LAST);

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
            prev_ok   <= 1'b0;
            prev_del  <= 1'b0;
        end else begin
            prev_up   <= bt_up;
            prev_down <= bt_down;
            prev_ok   <= bt_ok;
            prev_del  <= bt_del;
        end
    end

    // Edge detection and single-action priority: ok > del > up > down.
    always_comb begin
        e_up     = bt_up & ~prev_up;
        e_down   = bt_down & ~prev_down;
        e_ok     = bt_ok & ~prev_ok;
        e_del    = bt_del & ~prev_del;
        act_ok   = e_ok;
        act_del  = e_del & ~e_ok;
        act_up   = e_up & ~e_ok & ~e_del;
        act_down = e_down & ~e_ok & ~e_del & ~e_up;
    end

    // Round-robin search for the next pending channel after the last grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_CH_U; k++) begin
            idx = (32'(last) + k) % N_CH_U;
            if (!gnt_valid && pending[idx[CH_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[CH_W-1:0];
            end
        end
    end

    // UI FSM, per-channel day counting and pump arbitration.
    // Later assignments to pending/days_left override earlier ones, which
    // gives commit precedence over a same-cycle day_tick and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SELECT;
            sel      <= '0;
            edit_val <= '0;
            pending  <= '0;
            pump     <= '0;
            pump_cnt <= '0;
            last     <= SEL_LAST;
            for (int unsigned k = 0; k < N_CH_U; k++) begin
                period[k]    <= '0;
                days_left[k] <= '0;
            end
        end else begin
            if (pump != '0) begin
                if (pump_cnt == '0) begin
                    pump <= '0;
                end else begin
                    pump_cnt <= pump_cnt - 1'b1;
                end
            end else if (gnt_valid) begin
                pump             <= N_CH'(1) << gnt_idx;
                pump_cnt         <= CNT_LOAD;
                last             <= gnt_idx;
                pending[gnt_idx] <= 1'b0;
            end

            if (day_tick) begin
                for (int unsigned k = 0; k < N_CH_U; k++) begin
                    if (period[k] != '0) begin
                        if (days_left[k] <= PERIOD_W'(1)) begin
                            pending[k]   <= 1'b1;
                            days_left[k] <= period[k];
                        end else begin
                            days_left[k] <= days_left[k] - 1'b1;
                        end
                    end
                end
            end

            case (state)
                S_SELECT: begin
                    if (act_ok) begin
                        state    <= S_EDIT;
                        edit_val <= period[sel];
                    end else if (act_up) begin
                        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                    end else if (act_down) begin
                        sel <= (sel == '0) ? SEL_LAST : sel - 1'b1;
                    end
`ifdef MANUAL_RUN_EN
                    if (act_del) begin
                        pending[sel] <= 1'b1;
                    end
`endif
                end
                S_EDIT: begin
                    if (act_ok) begin
                        period[sel]    <= edit_val;
                        days_left[sel] <= edit_val;
                        pending[sel]   <= 1'b0;
                        state          <= S_SELECT;
                    end else if (act_del) begin
                        state <= S_SELECT;
                    end else if (act_up) begin
                        if (edit_val != '1) edit_val <= edit_val + 1'b1;
                    end else if (act_down) begin
                        if (edit_val != '0) edit_val <= edit_val - 1'b1;
                    end
                end
                default: state <= S_SELECT;
            endcase
        end
    end

    assign disp_ch   = sel;
    assign disp_edit = (state == S_EDIT);
    assign disp_val  = (state == S_EDIT) ? edit_val : period[sel];

endmodule

// File: tb/tb_irrigacao_sched.sv
// Testbench for irrigacao_sched: behavioural reference model plus directed
// literal checks, followed by randomized button activity.
module tb_irrigacao_sched;

    localparam int N = 3;
    localparam int W = 4;
    localparam int T = 10;
    localparam int P = 4;
    localparam int MAXV = 15;
    localparam int UP = 0, DN = 1, OK = 2, DEL = 3;
`ifdef MANUAL_RUN_EN
    localparam bit MAN = 1'b1;
`else
    localparam bit MAN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         bt_up = 1'b0, bt_down = 1'b0, bt_ok = 1'b0, bt_del = 1'b0;
    logic [N-1:0] pump;
    logic [1:0]   disp_ch;
    logic [W-1:0] disp_val;
    logic         disp_edit;

    int vectors = 0;
    int miscompares = 0;

    irrigacao_sched #(.N_CH(N), .PERIOD_W(W), .TICKS_PER_DAY(T), .PUMP_TICKS(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .bt_up(bt_up), .bt_down(bt_down), .bt_ok(bt_ok), .bt_del(bt_del),
        .pump(pump), .disp_ch(disp_ch), .disp_val(disp_val), .disp_edit(disp_edit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, one "owner + remaining cycles" pump.
    int m_edit, m_sel, m_ev, m_pch, m_rem, m_last, m_cyc;
    int m_per [N];
    int m_days[N];
    int m_pend[N];
    bit pv_up, pv_dn, pv_ok, pv_del;

    task automatic model_reset();
        m_edit = 0; m_sel = 0; m_ev = 0; m_pch = -1; m_rem = 0;
        m_last = N - 1; m_cyc = 0;
        pv_up = 0; pv_dn = 0; pv_ok = 0; pv_del = 0;
        for (int k = 0; k < N; k++) begin
            m_per[k] = 0; m_days[k] = 0; m_pend[k] = 0;
        end
    endtask

    task automatic model_step();
        int opend[N];
        int oper[N];
        int odays[N];
        bit eu, ed, eo, ex, au, ad, ao, ax, found, tick;
        int g;
        eu = bt_up && !pv_up;  ed = bt_down && !pv_dn;
        eo = bt_ok && !pv_ok;  ex = bt_del && !pv_del;
        pv_up = bt_up; pv_dn = bt_down; pv_ok = bt_ok; pv_del = bt_del;
        ao = eo;
        ax = ex && !eo;
        au = eu && !eo && !ex;
        ad = ed && !eo && !ex && !eu;
        opend = m_pend; oper = m_per; odays = m_days;

        if (m_pch >= 0) begin
            m_rem--;
            if (m_rem == 0) m_pch = -1;
        end else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                g = (m_last + k) % N;
                if (!found && opend[g] != 0) begin
                    found = 1; m_pch = g; m_rem = P; m_last = g; m_pend[g] = 0;
                end
            end
        end

        tick = (m_cyc == T - 1);
        m_cyc = tick ? 0 : m_cyc + 1;
        if (tick) begin
            for (int k = 0; k < N; k++) begin
                if (oper[k] != 0) begin
                    if (odays[k] <= 1) begin
                        m_pend[k] = 1; m_days[k] = oper[k];
                    end else begin
                        m_days[k] = odays[k] - 1;
                    end
                end
            end
        end

        if (m_edit == 0) begin
            if (ao) begin
                m_edit = 1; m_ev = oper[m_sel];
            end else if (ax) begin
                if (MAN) m_pend[m_sel] = 1;
            end else if (au) begin
                m_sel = (m_sel + 1) % N;
            end else if (ad) begin
                m_sel = (m_sel + N - 1) % N;
            end
        end else begin
            if (ao) begin
                m_per[m_sel] = m_ev; m_days[m_sel] = m_ev; m_pend[m_sel] = 0; m_edit = 0;
            end else if (ax) begin
                m_edit = 0;
            end else if (au) begin
                m_ev = (m_ev < MAXV) ? m_ev + 1 : MAXV;
            end else if (ad) begin
                m_ev = (m_ev > 0) ? m_ev - 1 : 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("pump", int'(pump), (m_pch >= 0) ? (1 << m_pch) : 0);
        chk("disp_ch", int'(disp_ch), m_sel);
        chk("disp_val", int'(disp_val), (m_edit != 0) ? m_ev : m_per[m_sel]);
        chk("disp_edit", int'(disp_edit), m_edit);
        chk("pump_onehot0", int'($countones(pump) <= 1), 1);
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            UP:      bt_up = v;
            DN:      bt_down = v;
            OK:      bt_ok = v;
            default: bt_del = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
    endtask

    initial begin
        bit seen;
        int prevp;
        int cnt;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ch", int'(disp_ch), 0);
        chk("rst_val", int'(disp_val), 0);
        chk("rst_edit", int'(disp_edit), 0);
        chk("rst_pump", int'(pump), 0);

        // Channel navigation with wrap.
        press(DN);
        chk("nav_wrap_down", int'(disp_ch), 2);
        press(UP); press(UP);
        chk("nav_up2", int'(disp_ch), 1);
        chk("nav_val", int'(disp_val), 0);
        chk("nav_edit", int'(disp_edit), 0);

        // Saturation high/low and cancel.
        press(DN);
        press(OK);
        repeat (20) press(UP);
        press(OK);
        chk("sat_hi", int'(disp_val), 15);
        chk("sat_hi_edit", int'(disp_edit), 0);
        press(OK);
        repeat (20) press(DN);
        chk("sat_lo", int'(disp_val), 0);
        chk("sat_lo_edit", int'(disp_edit), 1);
        press(DEL);
        chk("cancel_keeps", int'(disp_val), 15);
        chk("cancel_edit", int'(disp_edit), 0);

        // Periods 1,1,2 then let the scheduler run.
        press(OK);
        repeat (14) press(DN);
        press(OK);
        chk("p0_set", int'(disp_val), 1);
        press(UP); press(OK); press(UP); press(OK);
        chk("p1_set", int'(disp_val), 1);
        press(UP); press(OK); press(UP); press(UP); press(OK);
        chk("p2_set", int'(disp_val), 2);
        repeat (80) @(negedge clk);

        // All buttons rising together in EDIT: only ok acts, held levels don't repeat.
        press(OK);
        press(UP);
        @(negedge clk);
        bt_up = 1'b1; bt_down = 1'b1; bt_ok = 1'b1; bt_del = 1'b1;
        @(negedge clk);
        chk("all_edit", int'(disp_edit), 0);
        chk("all_val", int'(disp_val), 3);
        chk("all_ch", int'(disp_ch), 2);
        repeat (3) @(negedge clk);
        chk("hold_ch", int'(disp_ch), 2);
        chk("hold_edit", int'(disp_edit), 0);
        bt_up = 1'b0; bt_down = 1'b0; bt_ok = 1'b0; bt_del = 1'b0;

        // Asynchronous reset in the middle of a pump[1] watering.
        seen = 0;
        prevp = int'(pump);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (pump == 3'b010 && prevp != 2) seen = 1;
            prevp = int'(pump);
        end
        chk("wait_pump1", int'(seen), 1);
        if (seen) begin
            @(posedge clk);
            #2;
            chk("pre_rst_pump", int'(pump), 2);
            #1 rst_n = 1'b0;
            #1;
            chk("arst_pump", int'(pump), 0);
            chk("arst_ch", int'(disp_ch), 0);
            chk("arst_val", int'(disp_val), 0);
            chk("arst_edit", int'(disp_edit), 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            cnt = 0;
            repeat (60) begin
                @(negedge clk);
                if (pump != '0) cnt++;
            end
            chk("no_water_after_rst", cnt, 0);
        end

        // Manual run request on channel 2 (only effective with MANUAL_RUN_EN).
        press(DN);
        chk("man_sel", int'(disp_ch), 2);
        @(negedge clk);
        bt_del = 1'b1;
        @(negedge clk);
        bt_del = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("manual_pump", int'(pump), (MAN && i >= 1 && i <= 4) ? 4 : 0);
        end

        // Randomized button activity against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bt_up   = ($urandom_range(0, 5) == 0);
            bt_down = ($urandom_range(0, 5) == 0);
            bt_ok   = ($urandom_range(0, 7) == 0);
            bt_del  = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        bt_up = 1'b0; bt_down = 1'b0; bt_ok = 1'b0; bt_del = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
